// File: rtl/pc_branch_unit_pkg.sv
// Shared encodings for the LEGv8 next-PC / branch-target unit.
// Branch-mode and FSM state types, fetch increment, and the taken-condition helper.
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_UNCOND = 2'b01,
        BR_CBZ    = 2'b10,
        BR_REG    = 2'b11
    } br_mode_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Branch condition only; the valid qualifier is applied by the caller.
    function automatic logic branch_cond(br_mode_e mode, logic neg, logic zero);
        logic res;
        res = 1'b0;
        case (mode)
            BR_UNCOND: res = 1'b1;
            BR_REG:    res = 1'b1;
            BR_CBZ:    res = zero ^ neg;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_branch_unit_target_adder.sv
// pc_target_adder: PC + (sign-extended word offset << 2), wrapping at PC_W bits.
module pc_target_adder #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned IMM_W = 26
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  target
);
    localparam int unsigned EXT_W = (IMM_W + 2 > PC_W) ? IMM_W + 2 : PC_W;

    logic signed [EXT_W-1:0] offset;
    logic                    unused_ext;

    always_comb begin
        offset = EXT_W'($signed({imm, 2'b00}));
        target = pc + offset[PC_W-1:0];
    end

    // Bits above PC_W only matter for wider PCs; modulo arithmetic discards them.
    assign unused_ext = ^offset;

endmodule

// File: rtl/pc_branch_unit.sv
// Registered next-PC generator with BOOT/RUN/FLUSH sequencing, stall hold and redirect pulse.
// Optional misaligned-BR detection enabled by defining PC_ALIGN_CHECK_EN.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned     PC_W      = 12,
    parameter int unsigned     IMM_W     = 26,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [1:0]       br_mode,
    input  logic             br_neg,
    input  logic             cond_zero,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [63:0]      reg_target,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             redirect,
    output logic             align_fault
);
    state_e          state;
    br_mode_e        mode;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] rel_tgt;
    logic [PC_W-1:0] reg_tgt;
    logic [PC_W-1:0] target;
    logic            taken;
    logic            align_err;
    logic            unused_bits;

    assign mode = br_mode_e'(br_mode);

    pc_target_adder #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_adder (
        .pc     (pc),
        .imm    (br_imm),
        .target (rel_tgt)
    );

    always_comb begin
        pc_seq    = pc + PC_W'(PC_INC);
        reg_tgt   = reg_target[PC_W-1:0];
        taken     = br_valid && branch_cond(mode, br_neg, cond_zero);
        align_err = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        // A misaligned register target turns the branch into a plain sequential fetch.
        if (taken && (mode == BR_REG) && (reg_target[1:0] != 2'b00)) begin
            taken     = 1'b0;
            align_err = 1'b1;
        end
`else
        reg_tgt[1:0] = 2'b00;
`endif
        target = (mode == BR_REG) ? reg_tgt : rel_tgt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_VEC;
            pc_valid <= 1'b0;
            redirect <= 1'b0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (taken) begin
                        pc       <= target;
                        redirect <= 1'b1;
                        pc_valid <= 1'b0;
                        state    <= ST_FLUSH;
                    end else begin
                        pc <= pc_seq;
                    end
                end
                ST_FLUSH: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (!stall && (state == ST_RUN) && align_err) begin
            fault_q <= 1'b1;
        end
    end

    assign align_fault = fault_q;
    assign unused_bits = ^reg_target[63:PC_W];
`else
    assign align_fault = 1'b0;
    assign unused_bits = ^{reg_target[63:PC_W], reg_target[1:0], align_err};
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, async-reset sequence,
// and randomized traffic against a behavioural next-PC model.
module tb_pc_branch_unit;

    localparam int unsigned PC_W   = 12;
    localparam int unsigned IMM_W  = 26;
    localparam longint      PC_MOD = 64'd1 << PC_W;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             stall;
    logic             br_valid;
    logic [1:0]       br_mode;
    logic             br_neg;
    logic             cond_zero;
    logic [IMM_W-1:0] br_imm;
    logic [63:0]      reg_target;
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic             redirect;
    logic             align_fault;

    int errors = 0;
    int checks = 0;

    pc_branch_unit #(
        .PC_W      (PC_W),
        .IMM_W     (IMM_W),
        .RESET_VEC (12'd0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_mode     (br_mode),
        .br_neg      (br_neg),
        .cond_zero   (cond_zero),
        .br_imm      (br_imm),
        .reg_target  (reg_target),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .redirect    (redirect),
        .align_fault (align_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit               st;
        bit               bv;
        logic [1:0]       mode;
        bit               neg;
        bit               cz;
        logic [IMM_W-1:0] imm;
        logic [63:0]      tgt;
        int               epc;
        bit               ev;
        bit               er;
        bit               ef;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: a non-fetch cycle (boot or bubble) always becomes a real fetch next.
    int m_pc;
    bit m_valid;
    bit m_redir;
    bit m_fault;

    function automatic vec_t mk(bit st, bit bv, int mode, bit neg, bit cz, int imm,
                                logic [63:0] tgt, int epc, bit ev, bit er, bit ef);
        vec_t v;
        v.st = st; v.bv = bv; v.mode = 2'(mode); v.neg = neg; v.cz = cz;
        v.imm = IMM_W'(imm); v.tgt = tgt;
        v.epc = epc; v.ev = ev; v.er = er; v.ef = ef;
        return v;
    endfunction

    function automatic int wrap(longint x);
        return int'(((x % PC_MOD) + PC_MOD) % PC_MOD);
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_valid = 1'b0; m_redir = 1'b0; m_fault = 1'b0;
    endfunction

    function automatic void model_step(vec_t v);
        bit     tk;
        longint off;
        int     rt;
        m_redir = 1'b0;
        if (v.st) return;
        if (!m_valid) begin
            m_valid = 1'b1;
            return;
        end
        tk = v.bv && (v.mode == 2'd1 || v.mode == 2'd3 || (v.mode == 2'd2 && (v.cz ^ v.neg)));
        rt = int'(v.tgt % 64'(PC_MOD));
        if (tk && v.mode == 2'd3 && (rt % 4) != 0 && ALN) begin
            tk = 1'b0;
            m_fault = 1'b1;
        end
        if (tk) begin
            off = longint'($signed(v.imm)) * 4;
            m_pc = (v.mode == 2'd3) ? (rt - (rt % 4)) : wrap(longint'(m_pc) + off);
            m_redir = 1'b1;
            m_valid = 1'b0;
        end else begin
            m_pc = wrap(longint'(m_pc) + 4);
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit use_table, input string tag);
        stall = v.st; br_valid = v.bv; br_mode = v.mode; br_neg = v.neg;
        cond_zero = v.cz; br_imm = v.imm; reg_target = v.tgt;
        model_step(v);
        @(posedge clock);
        #1;
        chk({tag, ".pc"},          int'(pc),          use_table ? v.epc : m_pc);
        chk({tag, ".pc_valid"},    int'(pc_valid),    use_table ? int'(v.ev) : int'(m_valid));
        chk({tag, ".redirect"},    int'(redirect),    use_table ? int'(v.er) : int'(m_redir));
        chk({tag, ".align_fault"}, int'(align_fault), use_table ? int'(v.ef) : int'(m_fault));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},          int'(pc),          0);
        chk({tag, ".pc_valid"},    int'(pc_valid),    0);
        chk({tag, ".redirect"},    int'(redirect),    0);
        chk({tag, ".align_fault"}, int'(align_fault), 0);
    endtask

    initial begin
        vec_t v;
        // boot and sequential fetch
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    0, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    4, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    8, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,   12, 1,0,0));
        // B from 300, imm 8
        vq.push_back(mk(0,1,3,0,0, 0, 64'd300, 300, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  300, 1,0,0));
        vq.push_back(mk(0,1,1,0,0, 8, 64'd0,  332, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  332, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  336, 1,0,0));
        // CBZ false, then CBNZ true
        vq.push_back(mk(0,1,3,0,0, 0, 64'd300, 300, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  300, 1,0,0));
        vq.push_back(mk(0,1,2,0,0, 5, 64'd0,  304, 1,0,0));
        vq.push_back(mk(0,1,3,0,0, 0, 64'd300, 300, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  300, 1,0,0));
        vq.push_back(mk(0,1,2,1,0, 5, 64'd0,  320, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  320, 1,0,0));
        // wrap both directions
        vq.push_back(mk(0,1,3,0,0, 0, 64'd4092, 4092, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0, 4092, 1,0,0));
        vq.push_back(mk(0,1,1,0,0, 2, 64'd0,    4, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    4, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    8, 1,0,0));
        vq.push_back(mk(0,1,1,0,0,-3, 64'd0, 4092, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0, 4092, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,    0, 1,0,0));
        // branch presented during the bubble is ignored
        vq.push_back(mk(0,1,1,0,0,100, 64'd0, 400, 0,1,0));
        vq.push_back(mk(0,1,1,0,0,100, 64'd0, 400, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  404, 1,0,0));
        // stall holds a pending B, release takes it once
        vq.push_back(mk(1,1,1,0,0, 4, 64'd0,  404, 1,0,0));
        vq.push_back(mk(1,1,1,0,0, 4, 64'd0,  404, 1,0,0));
        vq.push_back(mk(1,1,1,0,0, 4, 64'd0,  404, 1,0,0));
        vq.push_back(mk(0,1,1,0,0, 4, 64'd0,  420, 0,1,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  420, 1,0,0));
        // stall during the bubble extends it
        vq.push_back(mk(0,1,1,0,0, 1, 64'd0,  424, 0,1,0));
        vq.push_back(mk(1,0,0,0,0, 0, 64'd0,  424, 0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0, 64'd0,  424, 0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  424, 1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,  428, 1,0,0));
        // misaligned BR target
        vq.push_back(mk(0,1,3,0,0, 0, 64'h102, ALN ? 432 : 256, ALN, !ALN, ALN));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0,   ALN ? 436 : 256, 1, 0, ALN));
        // BR uses only the low PC_W bits
        vq.push_back(mk(0,1,3,0,0, 0, 64'hABCD_0000_0000_0F04, 3844, 0,1,ALN));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0, 3844, 1,0,ALN));
        vq.push_back(mk(0,1,2,0,1,-1, 64'd0, 3840, 0,1,ALN));
        vq.push_back(mk(0,0,0,0,0, 0, 64'd0, 3840, 1,0,ALN));
        vq.push_back(mk(0,0,1,0,0, 8, 64'd0, 3844, 1,0,ALN));

        reset_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_mode = 2'd0;
        br_neg = 1'b0; cond_zero = 1'b0; br_imm = '0; reg_target = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_reset_state("reset");

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i], 1'b1, $sformatf("vec%0d", i));
        end

        // async reset in the middle of a redirect bubble
        v = mk(0,1,1,0,0, 3, 64'd0, 3856, 0,1,ALN);
        step(v, 1'b1, "pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_reset_state("rst_release");
        v = mk(0,1,1,0,0, 7, 64'd0, 0, 0,0,0);
        step(v, 1'b0, "boot_ign");
        v = mk(0,0,0,0,0, 0, 64'd0, 0, 0,0,0);
        step(v, 1'b0, "boot_seq");

        for (int i = 0; i < 400; i++) begin
            v.st   = ($urandom_range(0, 4) == 0);
            v.bv   = ($urandom_range(0, 3) != 0);
            v.mode = 2'($urandom_range(0, 3));
            v.neg  = 1'($urandom);
            v.cz   = 1'($urandom);
            v.imm  = ($urandom_range(0, 3) == 0) ? IMM_W'($urandom)
                                                 : IMM_W'(int'($urandom_range(0, 63)) - 32);
            v.tgt  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) v.tgt[1:0] = 2'b00;
            step(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
